aes_host_drv: RTL and testbench
===============================

AES_HOST_DRV -- requirements
Module: aes_host_drv

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024: maximum cycles spent waiting for OK before the operation aborts.
REQ-002 CLK  in  1  single clock; all logic rising-edge.
REQ-003 RST_  in  1  reset, asynchronous and active-low.
REQ-004 start  in  1  user request; sampled only in IDLE.
REQ-005 load_key  in  1  sampled with start; 1 = send key phase, 0 = reuse the key already held by the chip.
REQ-006 key  in  128  AES key; latched on accepted start.
REQ-007 data_in  in  128  plaintext block; latched on accepted start.
REQ-008 busy  out  1  high from the cycle after accepted start until return to IDLE.
REQ-009 done  out  1  one-cycle pulse marking operation end (success or timeout).
REQ-010 err  out  1  valid with done; 1 = OK timeout.
REQ-011 result  out  128  ciphertext; valid from done until the next accepted start.
REQ-012 CMD  out  2  chip command: 00 NOP, 01 KEY byte, 10 DATA byte, 11 READ byte.
REQ-013 DIN  out  8  byte to chip.
REQ-014 READY  in  1  chip accepts/provides a byte this cycle.
REQ-015 OK  in  1  chip result available.
REQ-016 DOUT  in  8  byte from chip.

Function
REQ-017 States: IDLE, KEY, DATA, WAIT, READ, FIN; single-cycle registered transitions.
REQ-018 IDLE: CMD=00, DIN=00; start=1 latches key/data_in, enters KEY if load_key=1, else DATA.
REQ-019 KEY: CMD=01, DIN=key byte; byte 0 = key[127:120], MSB-first.
REQ-020 DATA: CMD=10, DIN=data byte; same ordering as KEY.
REQ-021 A byte counts as transferred only on a cycle with READY=1; READY=0 holds CMD, DIN and the byte index unchanged (stall of any length).
REQ-022 4-bit byte index wraps 15->0; the transfer of byte 15 moves KEY->DATA, DATA->WAIT, READ->FIN.
REQ-023 WAIT: CMD=00; OK=1 enters READ the next cycle; the timeout counter is cleared on entry and increments each cycle.
REQ-024 Counter reaching TIMEOUT_CYC-1 with OK=0 enters FIN with err=1; OK=1 on that same cycle takes precedence (enters READ).
REQ-025 READ: CMD=11; each READY=1 cycle shifts DOUT into result, first byte -> result[127:120].
REQ-026 FIN: CMD=00; done=1 for exactly one cycle; err=1 only for the timeout path; next state IDLE.
REQ-027 On timeout, result holds its pre-start value.
REQ-028 start while busy is ignored; no queueing.
REQ-029 Latency with READY held at 1 and load_key=1: 32 send cycles + WAIT + 16 read cycles + FIN; minimum 51 cycles from start to done when OK is already high on WAIT entry.
REQ-030 READY and OK are used directly; synchronous single-clock chip interface.

Reset
REQ-031 RST_=0 asynchronously forces IDLE, CMD=00, DIN=00, busy=0, done=0, err=0, result=0, byte index=0, timeout counter=0.
REQ-032 RST_ asserted mid-operation aborts it without a done pulse; after release the block is in IDLE and accepts start on the first clock.

Structure
REQ-033 Shared package aes_if_pkg holds: the CMD encodings, the state enumeration, BLOCK_BYTES=16, and the byte-index width.
REQ-034 One sub-module aes_byte_shreg: a 128-bit parallel-load, byte-shift register with enable. It is instantiated twice: for TX (key/data) and for RX (result).

Verification
REQ-035 FIPS-197 vector, READY=1 constant, OK on WAIT entry:
- key=000102030405060708090a0b0c0d0e0f, data=00112233445566778899aabbccddeeff;
- chip model returns 69c4e0d86a7b0430d8cdb78070b4c55a;
- required: result equals it, err=0, done at cycle 51.
REQ-036 Same vector with READY toggling 1,0,0,1…: bytes seen by the chip are identical and in order, none duplicated; the ciphertext matches.
REQ-037 load_key=0: no CMD=01 cycle is observed; 16 DATA bytes then READ; result correct.
REQ-038 TIMEOUT_CYC=8, OK held 0: FIN after 8 WAIT cycles, done=1, err=1, result unchanged from its pre-start value.
REQ-039 RST_ pulsed low during DATA byte 7: CMD=00 and busy=0 immediately; no done; the next start completes the full sequence correctly.
REQ-040 start pulsed during READ: ignored; exactly one done pulse, for the original request.

Source files
------------

// File: rtl/aes_if_pkg.sv
// aes_if_pkg: shared definitions for the AES chip host driver.
//   CMD_* : 2-bit chip command encodings
//   state_t : driver FSM states
//   BLOCK_BYTES / BLOCK_W / IDX_W : block size in bytes, bits, byte-index width
package aes_if_pkg;
   localparam logic [1:0] CMD_NOP  = 2'b00;
   localparam logic [1:0] CMD_KEY  = 2'b01;
   localparam logic [1:0] CMD_DATA = 2'b10;
   localparam logic [1:0] CMD_READ = 2'b11;
   localparam int BLOCK_BYTES = 16;
   localparam int BLOCK_W     = BLOCK_BYTES * 8;
   localparam int IDX_W       = $clog2(BLOCK_BYTES);
   typedef enum logic [2:0] {ST_IDLE, ST_KEY, ST_DATA, ST_WAIT, ST_READ, ST_FIN} state_t;
endpackage

// File: rtl/aes_byte_shreg.sv
// aes_byte_shreg: 128-bit parallel-load register that shifts left by one byte.
//   i_clk, i_rst_n : clock, async active-low reset (clears to 0)
//   i_load, i_load_val : parallel load (wins over shift)
//   i_shift, i_byte : shift left 8 bits, i_byte enters the low byte
//   o_q : register contents
module aes_byte_shreg
   import aes_if_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_load,
   input  logic [BLOCK_W-1:0] i_load_val,
   input  logic               i_shift,
   input  logic [7:0]         i_byte,
   output logic [BLOCK_W-1:0] o_q
);
   logic [BLOCK_W-1:0] r_q;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_q <= '0;
      else if (i_load) r_q <= i_load_val;
      else if (i_shift) r_q <= {r_q[BLOCK_W-9:0], i_byte};
   assign o_q = r_q;
endmodule

// File: rtl/aes_host_drv.sv
// aes_host_drv: drives a byte-serial AES chip (key, data, wait, read back).
//   CLK, RST_ : clock, async active-low reset
//   start, load_key, key, data_in : user request (sampled in IDLE)
//   busy, done, err, result : user status and ciphertext
//   CMD, DIN : command and byte to chip; READY, OK, DOUT : chip handshake and byte back
module aes_host_drv
   import aes_if_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024
)(
   input  logic               CLK,
   input  logic               RST_,
   input  logic               start,
   input  logic               load_key,
   input  logic [BLOCK_W-1:0] key,
   input  logic [BLOCK_W-1:0] data_in,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [BLOCK_W-1:0] result,
   output logic [1:0]         CMD,
   output logic [7:0]         DIN,
   input  logic               READY,
   input  logic               OK,
   input  logic [7:0]         DOUT
);
   localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
   state_t             r_state;
   logic [1:0]         r_cmd;
   logic [IDX_W-1:0]   r_idx;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy, r_done, r_err;
   logic [BLOCK_W-1:0] r_data;
   logic [BLOCK_W-1:0] w_tx, w_tx_val;
   logic               w_start, w_last, w_tx_load, w_tx_shift, w_rx_shift;

   assign w_start    = r_state == ST_IDLE && start;
   assign w_last     = READY && r_idx == IDX_W'(BLOCK_BYTES - 1);
   // TX register holds the key first (or data when the key is reused) and is
   // reloaded with the latched data block as the last key byte goes out
   assign w_tx_load  = w_start || (r_state == ST_KEY && w_last);
   assign w_tx_val   = w_start ? (load_key ? key : data_in) : r_data;
   assign w_tx_shift = READY && (r_state == ST_KEY || r_state == ST_DATA);
   assign w_rx_shift = READY && r_state == ST_READ;
   // TX shifts in zeros, so it is empty outside KEY/DATA and DIN reads 00 there
   assign DIN    = w_tx[BLOCK_W-1 -: 8];
   assign CMD    = r_cmd;
   assign busy   = r_busy;
   assign done   = r_done;
   assign err    = r_err;

   aes_byte_shreg u_tx (
      .i_clk(CLK), .i_rst_n(RST_), .i_load(w_tx_load), .i_load_val(w_tx_val),
      .i_shift(w_tx_shift), .i_byte(8'h00), .o_q(w_tx)
   );
   // RX is never loaded, so a timeout leaves the previous result intact
   aes_byte_shreg u_rx (
      .i_clk(CLK), .i_rst_n(RST_), .i_load(1'b0), .i_load_val('0),
      .i_shift(w_rx_shift), .i_byte(DOUT), .o_q(result)
   );

   always_ff @(posedge CLK or negedge RST_)
      if (!RST_) begin
         r_state <= ST_IDLE;
         r_cmd   <= CMD_NOP;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_data  <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: if (start) begin
               r_data  <= data_in;
               r_busy  <= 1'b1;
               r_idx   <= '0;
               r_state <= load_key ? ST_KEY : ST_DATA;
               r_cmd   <= load_key ? CMD_KEY : CMD_DATA;
            end
            ST_KEY: if (READY) begin
               r_idx <= r_idx + 1'b1;
               if (w_last) begin
                  r_state <= ST_DATA;
                  r_cmd   <= CMD_DATA;
               end
            end
            ST_DATA: if (READY) begin
               r_idx <= r_idx + 1'b1;
               if (w_last) begin
                  r_state <= ST_WAIT;
                  r_cmd   <= CMD_NOP;
                  r_cnt   <= '0;
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               // OK on the final count still wins over the timeout
               if (OK) begin
                  r_state <= ST_READ;
                  r_cmd   <= CMD_READ;
               end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  r_state <= ST_FIN;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
               end
            end
            ST_READ: if (READY) begin
               r_idx <= r_idx + 1'b1;
               if (w_last) begin
                  r_state <= ST_FIN;
                  r_cmd   <= CMD_NOP;
                  r_done  <= 1'b1;
               end
            end
            ST_FIN: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_aes_host_drv.sv
// tb_aes_host_drv: directed scoreboard bench for aes_host_drv with a byte-level chip model.
module tb_aes_host_drv;
   import aes_if_pkg::*;
   logic         CLK = 1'b0, RST_ = 1'b0, start = 1'b0, load_key = 1'b0, READY = 1'b0, OK = 1'b0;
   logic [127:0] key = '0, data_in = '0;
   logic [7:0]   DOUT = '0;
   logic         busy, done, err;
   logic [127:0] result;
   logic [1:0]   CMD;
   logic [7:0]   DIN;

   always #5 CLK = ~CLK;

   aes_host_drv #(.TIMEOUT_CYC(8)) dut (
      .CLK(CLK), .RST_(RST_), .start(start), .load_key(load_key), .key(key), .data_in(data_in),
      .busy(busy), .done(done), .err(err), .result(result), .CMD(CMD), .DIN(DIN),
      .READY(READY), .OK(OK), .DOUT(DOUT)
   );

   localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P2 = 128'hdeadbeef0123456789abcdeffedcba98;

   int n_cmp = 0, n_bad = 0;
   logic [9:0]   exp_q[$];
   logic [128:0] res_q[$];
   logic [127:0] chip_ct = '0;
   int rd_ptr = 0, mode = 0, cyc = 0, pi = 0;
   int n_done = 0, done_cyc = 0, start_cyc = 0, n_wait = 0, n_key = 0, n_dbytes = 0, n0 = 0;

   task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // one cycle of the chip model, evaluated at the falling edge
   task automatic tick();
      logic [128:0] e;
      @(negedge CLK);
      cyc++;
      pi++;
      READY = (mode == 0) || (pi % 3 == 0);
      if (done) begin
         n_done++;
         done_cyc = cyc;
         if (res_q.size() == 0) chk("extra_done", 129'(done), 129'(0));
         else begin
            e = res_q.pop_front();
            chk("result", 129'(result), 129'(e[127:0]));
            chk("err", 129'(err), 129'(e[128]));
         end
      end else if (busy && CMD == CMD_NOP) n_wait++;
      if (CMD == CMD_KEY) n_key++;
      if (READY && (CMD == CMD_KEY || CMD == CMD_DATA)) begin
         if (CMD == CMD_DATA) n_dbytes++;
         if (exp_q.size() == 0) chk("extra_byte", 129'({CMD, DIN}), 129'(0));
         else chk("tx_byte", 129'({CMD, DIN}), 129'(exp_q.pop_front()));
      end
      if (READY && CMD == CMD_READ) begin
         DOUT = chip_ct[127 - 8 * (rd_ptr % 16) -: 8];
         rd_ptr++;
      end
   endtask

   task automatic go(input logic lk, input logic [127:0] k, input logic [127:0] d,
                     input logic [127:0] ct, input logic exp_err, input logic [127:0] exp_res);
      for (int i = 0; i < 16; i++) if (lk) exp_q.push_back({CMD_KEY, k[127 - 8 * i -: 8]});
      for (int i = 0; i < 16; i++) exp_q.push_back({CMD_DATA, d[127 - 8 * i -: 8]});
      res_q.push_back({exp_err, exp_res});
      chip_ct = ct;
      rd_ptr = 0; n_wait = 0; n_key = 0; n_dbytes = 0;
      key = k; data_in = d; load_key = lk;
      start = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
      chk("busy_after_start", 129'(busy), 129'(1));
   endtask

   task automatic wait_done(input int budget, input int n_before);
      int i = 0;
      while (n_done == n_before && i < budget) begin
         tick();
         i++;
      end
      chk("done_seen", 129'(n_done != n_before), 129'(1));
   endtask

   initial begin
      OK = 1'b1;
      #12;
      chk("rst_cmd", 129'(CMD), 129'(0));
      chk("rst_din", 129'(DIN), 129'(0));
      chk("rst_busy", 129'(busy), 129'(0));
      chk("rst_done", 129'(done), 129'(0));
      chk("rst_err", 129'(err), 129'(0));
      chk("rst_result", 129'(result), 129'(0));
      @(negedge CLK);
      RST_ = 1'b1;

      go(1'b1, K, P, C, 1'b0, C);
      wait_done(200, 0);
      chk("done_cycle", 129'(done_cyc - start_cyc + 1), 129'(51));
      chk("wait_cycles", 129'(n_wait), 129'(1));
      chk("bytes_left", 129'(exp_q.size()), 129'(0));
      chk("read_bytes", 129'(rd_ptr), 129'(16));
      tick();
      chk("done_pulse_len", 129'(done), 129'(0));
      chk("busy_idle", 129'(busy), 129'(0));

      mode = 1;
      go(1'b1, K, P, C, 1'b0, C);
      wait_done(400, 1);
      chk("stall_bytes_left", 129'(exp_q.size()), 129'(0));
      chk("stall_read_bytes", 129'(rd_ptr), 129'(16));
      mode = 0;
      tick();

      go(1'b0, K, P, C, 1'b0, C);
      wait_done(200, 2);
      chk("no_key_cmd", 129'(n_key), 129'(0));
      chk("data_bytes", 129'(n_dbytes), 129'(16));
      chk("nokey_done_cycle", 129'(done_cyc - start_cyc + 1), 129'(35));
      tick();

      OK = 1'b0;
      go(1'b0, K, P2, P2, 1'b1, C);
      wait_done(200, 3);
      chk("timeout_wait_cycles", 129'(n_wait), 129'(8));
      chk("timeout_no_read", 129'(rd_ptr), 129'(0));
      OK = 1'b1;
      tick();

      go(1'b1, K, P, C, 1'b0, C);
      for (int i = 0; i < 100 && n_dbytes < 8; i++) tick();
      #2 RST_ = 1'b0;
      #1;
      chk("midrst_cmd", 129'(CMD), 129'(0));
      chk("midrst_busy", 129'(busy), 129'(0));
      chk("midrst_din", 129'(DIN), 129'(0));
      exp_q.delete();
      res_q.delete();
      n0 = n_done;
      tick();
      tick();
      chk("midrst_no_done", 129'(n_done), 129'(n0));
      RST_ = 1'b1;
      go(1'b1, K, P, C, 1'b0, C);
      wait_done(200, n0);
      chk("postrst_done_cycle", 129'(done_cyc - start_cyc + 1), 129'(51));
      chk("postrst_bytes_left", 129'(exp_q.size()), 129'(0));
      tick();

      n0 = n_done;
      go(1'b1, K, P, C, 1'b0, C);
      for (int i = 0; i < 100 && CMD != CMD_READ; i++) tick();
      key = P2; data_in = P2; load_key = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(200, n0);
      repeat (60) tick();
      chk("one_done", 129'(n_done - n0), 129'(1));
      chk("ignored_start_busy", 129'(busy), 129'(0));
      chk("ignored_start_bytes", 129'(exp_q.size()), 129'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
